int16_to_bfloat16: RTL and testbench

Multi-cycle converter from a 16-bit integer to bfloat16. It produces operands for the bfloat16 arithmetic blocks, such as the bfloat16 adder, which expect sign/8-bit exponent/7-bit mantissa words with bias 127. Normalization uses a one-bit-per-cycle FSM rather than a priority encoder, which keeps area small. Result rounding is round-to-nearest-even.

---
 rtl/int16_to_bfloat16.sv | 130 +++++++++++++
 tb/tb_int16_to_bfloat16.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/int16_to_bfloat16.sv
// 16-bit integer to bfloat16 converter: one-bit-per-cycle normalization, then a single rounding step.
// Optional macro I2BF_TRUNCATE_EN selects round-toward-zero instead of round-to-nearest-even.
`timescale 1ns/1ps
module int16_to_bfloat16 #(
  parameter int SIGNED_IN = 1
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        start,
  input  logic [15:0] a,
  output logic        ready,
  output logic        done,
  output logic [15:0] result,
  output logic        inexact
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ABS       = 3'd1,
    S_NORMALIZE = 3'd2,
    S_ROUND     = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t      r_state;
  logic [15:0] r_a;
  logic        r_sign;
  logic [15:0] r_mag;
  logic [7:0]  r_exp;
  logic [15:0] r_result;
  logic        r_inexact;
  logic        r_done;
  logic        r_ready;

  logic        w_sign;
  logic [15:0] w_mag;
  logic [6:0]  w_m;
  logic        w_guard;
  logic        w_sticky;
  logic        w_up;
  logic [7:0]  w_sum;
  logic        w_carry;

  // -32768 negates back to 16'h8000, which is exactly the right unsigned magnitude
  assign w_sign = (SIGNED_IN != 0) ? r_a[15] : 1'b0;
  assign w_mag  = w_sign ? (~r_a + 16'd1) : r_a;

  assign w_m      = r_mag[14:8];
  assign w_guard  = r_mag[7];
  assign w_sticky = |r_mag[6:0];

`ifdef I2BF_TRUNCATE_EN
  assign w_up = 1'b0;
`else
  logic w_lsb;
  assign w_lsb = r_mag[8];
  assign w_up  = w_guard & (w_sticky | w_lsb);
`endif

  assign w_sum   = {1'b0, w_m} + {7'd0, w_up};
  assign w_carry = w_sum[7];

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state   <= S_IDLE;
      r_a       <= 16'h0000;
      r_sign    <= 1'b0;
      r_mag     <= 16'h0000;
      r_exp     <= 8'd0;
      r_result  <= 16'h0000;
      r_inexact <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_ready <= 1'b0;
            r_state <= S_ABS;
          end
        end
        S_ABS: begin
          r_sign <= w_sign;
          r_mag  <= w_mag;
          r_exp  <= 8'd142;
          if (w_mag == 16'h0000) begin
            r_result  <= 16'h0000;
            r_inexact <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_state <= S_NORMALIZE;
          end
        end
        S_NORMALIZE: begin
          if (!r_mag[15]) begin
            r_mag <= {r_mag[14:0], 1'b0};
            r_exp <= r_exp - 8'd1;
          end else begin
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          // A mantissa carry leaves w_sum[6:0] at zero and bumps the exponent
          r_result  <= {r_sign, (w_carry ? r_exp + 8'd1 : r_exp), w_sum[6:0]};
          r_exp     <= w_carry ? r_exp + 8'd1 : r_exp;
          r_inexact <= w_guard | w_sticky;
          r_done    <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready   = r_ready;
  assign done    = r_done;
  assign result  = r_result;
  assign inexact = r_inexact;

endmodule

// File: tb/tb_int16_to_bfloat16.sv
// Scoreboard bench for int16_to_bfloat16: signed and unsigned instances, reference model built on IEEE doubles.
`timescale 1ns/1ps
module tb_int16_to_bfloat16;

  logic        clock;
  logic        nreset;
  logic        start_s, start_u;
  logic [15:0] a_s, a_u;
  logic        ready_s, ready_u;
  logic        done_s, done_u;
  logic [15:0] result_s, result_u;
  logic        inexact_s, inexact_u;

  int n_checks;
  int n_fail;
  int cyc;

  typedef struct {
    logic [15:0] a;
    logic [15:0] res;
    logic        inx;
    int          cap;
    int          lat;
  } exp_t;

  exp_t q_s[$];
  exp_t q_u[$];
  exp_t e_s, e_u;
  logic [15:0] last_s, last_u;

  int16_to_bfloat16 #(.SIGNED_IN(1)) u_dut_s (
    .clock(clock), .nreset(nreset), .start(start_s), .a(a_s),
    .ready(ready_s), .done(done_s), .result(result_s), .inexact(inexact_s)
  );

  int16_to_bfloat16 #(.SIGNED_IN(0)) u_dut_u (
    .clock(clock), .nreset(nreset), .start(start_u), .a(a_u),
    .ready(ready_u), .done(done_u), .result(result_u), .inexact(inexact_u)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference: convert through a double, then round its 52-bit fraction down to 7 bits.
  task automatic model(input bit sgn, input logic [15:0] val,
                       output logic [15:0] res, output logic inx, output int lat);
    int          v;
    real         r;
    logic [63:0] b;
    int          ex;
    logic [7:0]  exp8;
    logic [6:0]  m;
    logic [44:0] rest;
    logic        up;
    logic [14:0] body;
    v = sgn ? int'($signed(val)) : int'(val);
    if (v == 0) begin
      res = 16'h0000;
      inx = 1'b0;
      lat = 1;
    end else begin
      r    = v;
      b    = $realtobits(r);
      ex   = int'(b[62:52]) - 1023;
      exp8 = 8'(ex + 127);
      m    = b[51:45];
      rest = b[44:0];
`ifdef I2BF_TRUNCATE_EN
      up = 1'b0;
`else
      up = rest[44] && ((rest[43:0] != 44'd0) || m[0]);
`endif
      body = {exp8, m} + {14'd0, up};
      res  = {b[63], body};
      inx  = (rest != 45'd0);
      lat  = (15 - ex) + 3;
    end
  endtask

  task automatic push_exp(input bit sgn, input logic [15:0] val);
    exp_t e;
    e.a   = val;
    e.cap = cyc + 1;
    model(sgn, val, e.res, e.inx, e.lat);
    if (sgn) q_s.push_back(e);
    else     q_u.push_back(e);
  endtask

  task automatic drain(input bit sgn);
    int k;
    k = 0;
    while (((sgn ? q_s.size() : q_u.size()) != 0) && k < 40) begin
      @(negedge clock);
      k++;
    end
    @(negedge clock);
    check(sgn ? "drain_s" : "drain_u", sgn ? q_s.size() : q_u.size(), 0);
  endtask

  task automatic send(input bit sgn, input logic [15:0] val);
    int k;
    k = 0;
    @(negedge clock);
    while (!(sgn ? ready_s : ready_u) && k < 40) begin
      @(negedge clock);
      k++;
    end
    if (sgn) begin a_s = val; start_s = 1'b1; end
    else     begin a_u = val; start_u = 1'b1; end
    push_exp(sgn, val);
    @(negedge clock);
    if (sgn) begin start_s = 1'b0; a_s = ~val; end
    else     begin start_u = 1'b0; a_u = ~val; end
    drain(sgn);
  endtask

  always @(negedge clock) begin
    if (!nreset) begin
      last_s = 16'h0000;
    end else if (done_s) begin
      if (q_s.size() == 0) begin
        check("unexpected_done_s", {31'd0, done_s}, 32'd0);
      end else begin
        e_s = q_s.pop_front();
        check("result_s", {16'd0, result_s}, {16'd0, e_s.res});
        check("inexact_s", {31'd0, inexact_s}, {31'd0, e_s.inx});
        check("latency_s", cyc - e_s.cap, e_s.lat);
        $display("signed   a=%04h -> result=%04h inexact=%0b latency=%0d", e_s.a, result_s, inexact_s, cyc - e_s.cap);
      end
      last_s = result_s;
    end else begin
      check("hold_s", {16'd0, result_s}, {16'd0, last_s});
    end
  end

  always @(negedge clock) begin
    if (!nreset) begin
      last_u = 16'h0000;
    end else if (done_u) begin
      if (q_u.size() == 0) begin
        check("unexpected_done_u", {31'd0, done_u}, 32'd0);
      end else begin
        e_u = q_u.pop_front();
        check("result_u", {16'd0, result_u}, {16'd0, e_u.res});
        check("inexact_u", {31'd0, inexact_u}, {31'd0, e_u.inx});
        check("latency_u", cyc - e_u.cap, e_u.lat);
        $display("unsigned a=%04h -> result=%04h inexact=%0b latency=%0d", e_u.a, result_u, inexact_u, cyc - e_u.cap);
      end
      last_u = result_u;
    end else begin
      check("hold_u", {16'd0, result_u}, {16'd0, last_u});
    end
  end

  logic [15:0] vec_s [12];
  logic [15:0] vec_u [5];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    nreset   = 1'b0;
    start_s  = 1'b0;
    start_u  = 1'b0;
    a_s      = 16'h0000;
    a_u      = 16'h0000;
    vec_s = '{16'h0001, 16'h0000, 16'h8000, 16'h7FFF, 16'd257, 16'd259,
              16'hFFFF, 16'hFEFF, 16'h1234, 16'h00FF, 16'h4001, 16'hC3A7};
    vec_u = '{16'hFFFF, 16'h8000, 16'h0000, 16'h0001, 16'd257};

    repeat (2) @(negedge clock);
    check("reset_ready", {31'd0, ready_s}, 32'd1);
    check("reset_done", {31'd0, done_s}, 32'd0);
    check("reset_result", {16'd0, result_s}, 32'd0);
    check("reset_inexact", {31'd0, inexact_s}, 32'd0);
    nreset = 1'b1;

    // Leave a nonzero result behind so the abort visibly clears it
    send(1'b1, 16'h7FFF);

    @(negedge clock);
    a_s = 16'h0001;
    start_s = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start_s = 1'b0;
    repeat (4) @(posedge clock);
    #1 nreset = 1'b0;
    @(negedge clock);
    q_s.delete();
    check("abort_ready", {31'd0, ready_s}, 32'd1);
    check("abort_done", {31'd0, done_s}, 32'd0);
    check("abort_result", {16'd0, result_s}, 32'd0);
    check("abort_inexact", {31'd0, inexact_s}, 32'd0);
    @(negedge clock);
    nreset = 1'b1;

    foreach (vec_s[i]) send(1'b1, vec_s[i]);
    foreach (vec_u[i]) send(1'b0, vec_u[i]);

    // start held high while a changes every cycle: only IDLE-edge values get captured
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      start_s = 1'b1;
      case ($urandom_range(0, 3))
        0:       a_s = 16'h0000;
        1:       a_s = 16'h8000;
        default: a_s = 16'($urandom);
      endcase
      if (ready_s) push_exp(1'b1, a_s);
    end
    @(negedge clock);
    start_s = 1'b0;
    drain(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
